// File: rtl/fpmul_req_arbiter.sv
// fpmul_req_arbiter: round-robin sharing of one combinational FP32 multiplier among NREQ requesters.
// Latency: rsp_valid rises 2 cycles after the accept cycle; one op in flight, issue interval >= 3 cycles.
// Backpressure: req_ready only in IDLE; the response is held in RESP until rsp_ready. Optional FPMUL_ARB_STICKY_EN adds sticky flags.

// Single-cycle combinational FP32 multiply with exception/overflow/underflow flags.
// Denormal inputs are flushed to zero and the mantissa is truncated (round toward zero).
// Exception (either operand exponent all-ones) forces a zero result with the other flags clear.
module multiplication (
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   output logic [31:0] result,
   output logic        exception,
   output logic        overflow,
   output logic        underflow
);
   logic        sign;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic        zero_in;
   logic [23:0] man_a;
   logic [23:0] man_b;
   logic [47:0] product;
   logic        norm;
   logic [22:0] mantissa;
   logic [9:0]  exp_sum;
   logic        ovf_raw;
   logic        unf_raw;

   // unpack, multiply significands, normalise, rebias exponent and classify the result
   always_comb begin
      sign      = a_operand[31] ^ b_operand[31];
      exp_a     = a_operand[30:23];
      exp_b     = b_operand[30:23];
      exception = (&exp_a) | (&exp_b);
      zero_in   = (exp_a == 8'd0) | (exp_b == 8'd0);
      man_a     = {1'b1, a_operand[22:0]};
      man_b     = {1'b1, b_operand[22:0]};
      product   = {24'd0, man_a} * {24'd0, man_b};
      // product of two [1,2) significands lies in [1,4); bit 47 set means it reached 2
      norm      = product[47];
      mantissa  = norm ? product[46:24] : product[45:23];
      // 10-bit two's-complement exponent: range -125..382 fits without wrap
      exp_sum   = {2'b00, exp_a} + {2'b00, exp_b} + {9'd0, norm} - 10'd127;
      ovf_raw   = !exp_sum[9] && (exp_sum[8:0] >= 9'd255);
      unf_raw   = exp_sum[9] || (exp_sum == 10'd0);
      overflow  = !exception && !zero_in && ovf_raw;
      underflow = !exception && !zero_in && unf_raw;

      if (exception) begin
         result = 32'd0;
      end else if (zero_in) begin
         result = {sign, 31'd0};
      end else if (ovf_raw) begin
         result = {sign, 8'hFF, 23'd0};
      end else if (unf_raw) begin
         result = {sign, 31'd0};
      end else begin
         result = {sign, exp_sum[7:0], mantissa};
      end
   end
endmodule

module fpmul_req_arbiter #(
   parameter int NREQ  = 4,
   parameter int TAG_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_result,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_exception,
   output logic                 rsp_overflow,
   output logic                 rsp_underflow,
   output logic                 busy,
   output logic [2:0]           sticky_flags,
   input  logic                 flag_clr
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TAG_W-1:0] last_grant;
   logic [TAG_W-1:0] grant_idx;
   logic [TAG_W-1:0] cand;
   logic [TAG_W-1:0] tag_q;
   logic             grant_any;
   logic             accept;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      mul_result;
   logic             mul_exception;
   logic             mul_overflow;
   logic             mul_underflow;

   // round-robin search starting one past the previous winner, wrapping modulo NREQ
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = TAG_W'((int'(last_grant) + k) % NREQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // reset masks the grant so nothing is accepted while rst is high
   assign accept = (state == IDLE) && grant_any && !rst;

   // one-hot ready to the winner only, and only while accepting
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: accept -> one compute cycle -> hold response until taken
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // capture the winner's operands and remember it for the next rotation
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a       <= 32'd0;
         op_b       <= 32'd0;
         tag_q      <= '0;
         last_grant <= TAG_W'(NREQ - 1);
      end else if (accept) begin
         op_a       <= req_a[32*grant_idx +: 32];
         op_b       <= req_b[32*grant_idx +: 32];
         tag_q      <= grant_idx;
         last_grant <= grant_idx;
      end
   end

   // the multiplier only ever sees registered operands
   multiplication u_mul (
      .a_operand (op_a),
      .b_operand (op_b),
      .result    (mul_result),
      .exception (mul_exception),
      .overflow  (mul_overflow),
      .underflow (mul_underflow)
   );

   // latch the product and flags at the end of CALC; held through RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_result    <= 32'd0;
         rsp_tag       <= '0;
         rsp_exception <= 1'b0;
         rsp_overflow  <= 1'b0;
         rsp_underflow <= 1'b0;
      end else if (state == CALC) begin
         rsp_result    <= mul_result;
         rsp_tag       <= tag_q;
         rsp_exception <= mul_exception;
         rsp_overflow  <= mul_overflow;
         rsp_underflow <= mul_underflow;
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

`ifdef FPMUL_ARB_STICKY_EN
   logic [2:0] sticky_q;

   // accumulate flags of each delivered response; a clear beats a same-cycle handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 3'b000;
      end else if (flag_clr) begin
         sticky_q <= 3'b000;
      end else if (rsp_valid && rsp_ready) begin
         sticky_q <= sticky_q | {rsp_exception, rsp_overflow, rsp_underflow};
      end
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_flag_clr;

   assign unused_flag_clr = flag_clr;
   assign sticky_flags    = 3'b000;
`endif

endmodule

// File: doc/fpmul_req_arbiter.md
# fpmul_req_arbiter

Round-robin arbiter and sequencer that shares one combinational `multiplication` (single-precision FP multiply) instance among NREQ requesters. Each accepted request has its operands registered, is evaluated by the multiplier, and its result and status flags are captured. The result is returned on a single response port tagged with the requester index. The block sits between the ALU issue logic and the multiplier datapath, and is the only driver of the multiplier's operand inputs.

## Interface
- NREQ, 4: number of requesters, legal 2..8.
- TAG_W, 2: requester tag width; must equal clog2(NREQ).

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_result  out  32  product from the multiplier.
- rsp_tag  out  TAG_W  index of the requester that issued the operation.
- rsp_exception, rsp_overflow, rsp_underflow  out  1 each  multiplier flags for this result.
- busy  out  1  high in every state except IDLE.
- sticky_flags  out  3  {exception, overflow, underflow} accumulated; present only per Configuration.
- flag_clr  in  1  clears sticky_flags; present only per Configuration.

## Operation
- FSM has three states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - The grant is computed combinationally from req_valid.
  - Search order starts at last_grant+1 and proceeds modulo NREQ; the first valid requester wins.
  - req_ready[g] = 1 only for the winner g; all other ready bits are 0.
  - On a cycle with any req_valid high:
    - capture req_a/req_b slice g into op_a/op_b;
    - set tag_q = g and last_grant = g;
    - go to CALC.
  - With no request, stay in IDLE.
- CALC:
  - The multiplier inputs are op_a/op_b, driven only from the registers.
  - At the end of the cycle, capture result, Exception, Overflow and Underflow into the response registers, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_tag and the flags are held stable.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- req_ready is 0 in CALC and RESP.
- Requesters hold req_valid and their operands until accepted; dropping req_valid before acceptance is legal and withdraws the request.
- The multiplier result is passed through unmodified; the block performs no arithmetic of its own.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_tag = 0.
  - All rsp flags = 0, busy = 0, sticky_flags = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
- rst asserted mid-operation (CALC or RESP): the in-flight operation is discarded, no response is issued, and the FSM returns to IDLE next cycle.
- rst has priority over every other event.

## Timing
- Request accepted at edge E0 (IDLE, req_valid[g] & req_ready[g]).
- CALC occupies the cycle E0..E1.
- rsp_valid is high from E1 until the edge at which rsp_ready is sampled high, inclusive.
- Latency from acceptance to rsp_valid: 2 cycles. Minimum issue interval with rsp_ready held high: 3 cycles.
- The multiplier is one combinational cycle (op regs → response regs) and must close timing at the target clock.
- All outputs are registered except req_ready, which is combinational from req_valid and the state.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 grants.

## Configuration
- FPMUL_ARB_STICKY_EN defined:
  - sticky_flags ORs in rsp_exception, rsp_overflow and rsp_underflow on every RESP handshake.
  - flag_clr = 1 zeroes sticky_flags the next cycle.
  - If flag_clr and a handshake occur in the same cycle, clear wins; that handshake's flags are lost.
- FPMUL_ARB_STICKY_EN undefined:
  - sticky_flags is tied to 3'b000.
  - flag_clr is ignored and no sticky registers exist.

## Test plan
- Single request on req 0, a=0x40000000 (2.0), b=0x40400000 (3.0), rsp_ready=1 → rsp_valid 2 cycles after acceptance, rsp_result=0x40C00000, rsp_tag=0, all flags 0.
- All 4 requesters valid continuously, each with a=b=0x3FC00000 (1.5), rsp_ready=1 → grant order 0,1,2,3,0; every rsp_result=0x40100000; rsp_tag matches grant order.
- Req 2, a=0x7F000000, b=0x7F000000 → rsp_overflow=1, rsp_result=0x7F800000; req 1, a=0x7F800000, b=0x3F800000 → rsp_exception=1, rsp_result=0x00000000.
- Req 3, a=b=0x00800000 → rsp_underflow=1, rsp_result=0x00000000. Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_result stable, req_ready all 0, busy=1 throughout.
- rst asserted during CALC → next cycle FSM is IDLE, rsp_valid=0, no response ever issued for that op. Next request goes to requester 0 first.
- FPMUL_ARB_STICKY_EN defined: overflow op then underflow op → sticky_flags=3'b011. Pulse flag_clr → 3'b000 next cycle. Macro undefined → sticky_flags stays 0 for the same stimulus.
